mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: clk input 1 is the rising-edge clock; rst input 1 is a synchronous, active-high reset.
REQ-002 Per requester port n in {0,1}, the block SHALL have these inputs: reqN 1 (request); lockN 1 (hold ownership); addrN 32 (byte address); wdataN 32 (write data); wmodeN 3 (write mode, 0=NONE,1=BYTE,2=HALFWORD,3=WORD,4=WORDLEFT,5=WORDRIGHT); rmodeN 3 (read mode, same encoding); unsignedN 1 (unsigned load).
REQ-003 Per port n, the block SHALL have these outputs: gntN 1 (beat accepted this cycle); rvalidN 1 (read data valid); rdataN 32 (read data).
REQ-004 On the memory side, the block SHALL have these outputs: mem_address 32, mem_data 32, mem_writeMode 3, mem_readMode 3, mem_unsignedLoad 1.
REQ-005 On the memory side, the block SHALL have input mem_dataOutput 32, which holds the memory read result one clk after the command.

Function
REQ-006 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-007 gntN SHALL be combinational: it is high in the same cycle as reqN when port N wins. A beat is transferred when reqN&gntN.
REQ-008 When a port is granted, the memory-side outputs SHALL equal that port's addr/wdata/wmode/rmode/unsigned in the same cycle.
REQ-009 With no grant, the memory-side outputs SHALL be: mem_address=0, mem_data=0, both modes=0 (NONE), mem_unsignedLoad=0.
REQ-010 The owner state machine SHALL have states IDLE, OWN0 and OWN1.
REQ-011 In IDLE, the arbitration winner SHALL be granted. If the winner's lock is high, the next state is OWN(winner); otherwise the state stays IDLE.
REQ-012 In OWNn, only port n SHALL be granted; the other port waits even if requesting. This holds only while reqn is high.
REQ-013 In OWNn, when reqn=0 or lockn=0 the state SHALL return to IDLE next cycle. A beat presented that cycle with reqn=1 is still granted.
REQ-014 A 4-bit locked-beat counter SHALL increment on each granted beat in OWNn. It clears on entry to OWNn and in IDLE.
REQ-015 On the 16th consecutive locked beat, the block SHALL force IDLE next cycle. It then grants the other port for one beat if that port is requesting, before port n may own again.
REQ-016 rvalidN SHALL be registered: it is high one cycle after a granted beat with wmodeN=0 and rmodeN!=0, and low otherwise.
REQ-017 A granted beat with wmodeN!=0 SHALL be treated as a write and SHALL produce no rvalid, regardless of rmodeN.
REQ-018 rdataN SHALL equal mem_dataOutput when rvalidN=1, and 0 otherwise.
REQ-019 Back-to-back reads from alternating ports SHALL each receive their own rvalid in consecutive cycles. The port identity travels with the 1-cycle delay, not with the current grant.
REQ-020 lockN with reqN=0 SHALL have no effect.

Reset
REQ-021 Synchronous rst=1 SHALL force: state=IDLE, counter=0, rvalid0=rvalid1=0, last-grant register=1.
REQ-022 During rst, gnt0=gnt1=0 and the memory-side outputs SHALL take the REQ-009 idle values.
REQ-023 Reset asserted mid-lock or with a read in flight SHALL abandon the operation: no rvalid is issued in the cycle after reset.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN SHALL select the IDLE arbitration policy.
REQ-025 When ARB_ROUND_ROBIN_EN is defined, in IDLE with both requesting, the port not granted last SHALL win. The last-grant register updates on every granted beat.
REQ-026 When ARB_ROUND_ROBIN_EN is undefined, port 0 SHALL always win in IDLE. The last-grant register is not implemented.
REQ-027 In both configurations, the REQ-015 forced release SHALL hand the one-beat grant to the other port.

Verification
REQ-028 Reset then req0 read (addr0=0x10, rmode0=WORD), mem_dataOutput=0xDEADBEEF next cycle -> gnt0=1 in cycle 0; rvalid0=1 and rdata0=0xDEADBEEF in cycle 1; rvalid1=0.
REQ-029 req0 and req1 both high for 4 cycles, no lock -> round-robin: grants 0,1,0,1. Fixed priority: grants 0,0,0,0 and gnt1 never asserted.
REQ-030 req0+lock0 for 20 beats with req1 high throughout -> gnt0 for beats 1-16, gnt1 for exactly one cycle, then gnt0 resumes.
REQ-031 Write on port1 (wmode1=BYTE, rmode1=BYTE, addr1=0x3, wdata1=0xAB) -> mem_writeMode=1 and mem_address=0x3 that cycle; rvalid1=0 the next cycle.
REQ-032 Read granted to port1, then rst=1 the next cycle -> rvalid1=0, state IDLE, all memory-side outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter with lock ownership, a 16-beat lock limit and registered read-valid return.
// Define ARB_ROUND_ROBIN_EN for round-robin idle arbitration; otherwise port 0 has fixed priority.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        lock0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [2:0]  wmode0,
    input  logic [2:0]  rmode0,
    input  logic        unsigned0,
    input  logic        req1,
    input  logic        lock1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [2:0]  wmode1,
    input  logic [2:0]  rmode1,
    input  logic        unsigned1,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_writeMode,
    output logic [2:0]  mem_readMode,
    output logic        mem_unsignedLoad,
    input  logic [31:0] mem_dataOutput
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    // The granting beat in IDLE is the first locked beat, so 15 beats in OWNn make 16.
    localparam logic [3:0] LOCK_LAST_CNT = 4'd14;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic        yield_q, yield_d;
    logic        yield_to_q, yield_to_d;
    logic        prefer1;
    logic        arb0, arb1;
    logic        hold0, hold1;
    logic        win0, win1;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;

    always_comb begin
        prefer1 = yield_q ? yield_to_q : ~last_q;
        last_d  = win1 ? 1'b1 : (win0 ? 1'b0 : last_q);
    end
`else
    always_comb begin
        prefer1 = yield_q & yield_to_q;
    end
`endif

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        arb0       = req0 & (~req1 | ~prefer1);
        arb1       = req1 & (~req0 | prefer1);
        hold0      = (state_q == OWN0) & req0;
        hold1      = (state_q == OWN1) & req1;
        win0       = 1'b0;
        win1       = 1'b0;
        state_d    = IDLE;
        yield_d    = 1'b0;
        yield_to_d = yield_to_q;

        if (hold0 || hold1) begin
            win0    = hold0;
            win1    = hold1;
            state_d = state_q;
            if (cnt_q == LOCK_LAST_CNT) begin
                state_d    = IDLE;
                yield_d    = 1'b1;
                yield_to_d = hold0;
            end else if ((hold0 && !lock0) || (hold1 && !lock1)) begin
                state_d = IDLE;
            end
        end else begin
            // An owner that drops its request no longer blocks the other port.
            win0 = arb0;
            win1 = arb1;
            if (arb0 && lock0) begin
                state_d = OWN0;
            end else if (arb1 && lock1) begin
                state_d = OWN1;
            end
        end

        cnt_d = ((hold0 || hold1) && state_d == state_q) ? cnt_q + 4'd1 : 4'd0;

        gnt0 = win0 & ~rst;
        gnt1 = win1 & ~rst;

        rvalid0_d = gnt0 & (wmode0 == 3'd0) & (rmode0 != 3'd0);
        rvalid1_d = gnt1 & (wmode1 == 3'd0) & (rmode1 != 3'd0);
    end

    always_comb begin
        mem_address      = 32'd0;
        mem_data         = 32'd0;
        mem_writeMode    = 3'd0;
        mem_readMode     = 3'd0;
        mem_unsignedLoad = 1'b0;
        if (gnt0) begin
            mem_address      = addr0;
            mem_data         = wdata0;
            mem_writeMode    = wmode0;
            mem_readMode     = rmode0;
            mem_unsignedLoad = unsigned0;
        end else if (gnt1) begin
            mem_address      = addr1;
            mem_data         = wdata1;
            mem_writeMode    = wmode1;
            mem_readMode     = rmode1;
            mem_unsignedLoad = unsigned1;
        end
    end

    // Masking with rst drops a read already in flight when reset arrives.
    always_comb begin
        rvalid0 = rvalid0_q & ~rst;
        rvalid1 = rvalid1_q & ~rst;
        rdata0  = rvalid0 ? mem_dataOutput : 32'd0;
        rdata1  = rvalid1 ? mem_dataOutput : 32'd0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            yield_q    <= 1'b0;
            yield_to_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            yield_q    <= yield_d;
            yield_to_q <= yield_to_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter: each row drives one cycle and checks grants and the memory-side mux,
// while a scoreboard queue carries the expected read-valid of each beat into the following cycle.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, lock0, unsigned0, req1, lock1, unsigned1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [2:0]  wmode0, rmode0, wmode1, rmode1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_data, mem_dataOutput;
    logic [2:0]  mem_writeMode, mem_readMode;
    logic        mem_unsignedLoad;

    mem_port_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req0             (req0),
        .lock0            (lock0),
        .addr0            (addr0),
        .wdata0           (wdata0),
        .wmode0           (wmode0),
        .rmode0           (rmode0),
        .unsigned0        (unsigned0),
        .req1             (req1),
        .lock1            (lock1),
        .addr1            (addr1),
        .wdata1           (wdata1),
        .wmode1           (wmode1),
        .rmode1           (rmode1),
        .unsigned1        (unsigned1),
        .gnt0             (gnt0),
        .rvalid0          (rvalid0),
        .rdata0           (rdata0),
        .gnt1             (gnt1),
        .rvalid1          (rvalid1),
        .rdata1           (rdata1),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_writeMode    (mem_writeMode),
        .mem_readMode     (mem_readMode),
        .mem_unsignedLoad (mem_unsignedLoad),
        .mem_dataOutput   (mem_dataOutput)
    );

    // exp_gnt: 0 = no grant, 1 = port 0, 2 = port 1
    typedef struct {
        logic        rst;
        logic        req0, lock0, us0, req1, lock1, us1;
        logic [31:0] addr0, wdata0, addr1, wdata1;
        logic [2:0]  wm0, rm0, wm1, rm1;
        logic [31:0] mdo;
        logic [1:0]  exp_gnt;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] sb[$];
    int         passed = 0;
    int         total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{default: 0};
        v.mdo = $urandom;
        return v;
    endfunction

    function automatic vec_t rd(input int port, input logic [31:0] addr, input logic [2:0] rm);
        vec_t v;
        v = blank();
        if (port == 0) begin
            v.req0 = 1'b1; v.addr0 = addr; v.rm0 = rm; v.wdata0 = addr ^ 32'h5555_0000; v.exp_gnt = 2'd1;
        end else begin
            v.req1 = 1'b1; v.addr1 = addr; v.rm1 = rm; v.wdata1 = addr ^ 32'h0000_AAAA; v.exp_gnt = 2'd2;
        end
        return v;
    endfunction

    // Two simultaneous reads from distinct addresses; caller sets the expected winner.
    function automatic vec_t both(input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] g);
        vec_t v, w;
        v = rd(0, a0, 3'd3);
        w = rd(1, a1, 3'd1);
        v.req1 = 1'b1; v.addr1 = w.addr1; v.rm1 = w.rm1; v.wdata1 = w.wdata1;
        v.exp_gnt = g;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ea, ed;
        logic [2:0]  ew, er;
        logic        eu;
        logic [1:0]  e;
        rst = v.rst;
        req0 = v.req0; lock0 = v.lock0; addr0 = v.addr0; wdata0 = v.wdata0;
        wmode0 = v.wm0; rmode0 = v.rm0; unsigned0 = v.us0;
        req1 = v.req1; lock1 = v.lock1; addr1 = v.addr1; wdata1 = v.wdata1;
        wmode1 = v.wm1; rmode1 = v.rm1; unsigned1 = v.us1;
        mem_dataOutput = v.mdo;
        #4;
        ea = 32'd0; ed = 32'd0; ew = 3'd0; er = 3'd0; eu = 1'b0;
        if (v.exp_gnt == 2'd1) begin
            ea = v.addr0; ed = v.wdata0; ew = v.wm0; er = v.rm0; eu = v.us0;
        end else if (v.exp_gnt == 2'd2) begin
            ea = v.addr1; ed = v.wdata1; ew = v.wm1; er = v.rm1; eu = v.us1;
        end
        check($sformatf("row%0d gnt0", idx), 32'(gnt0), 32'(v.exp_gnt == 2'd1));
        check($sformatf("row%0d gnt1", idx), 32'(gnt1), 32'(v.exp_gnt == 2'd2));
        check($sformatf("row%0d mem_address", idx), mem_address, ea);
        check($sformatf("row%0d mem_data", idx), mem_data, ed);
        check($sformatf("row%0d mem_writeMode", idx), 32'(mem_writeMode), 32'(ew));
        check($sformatf("row%0d mem_readMode", idx), 32'(mem_readMode), 32'(er));
        check($sformatf("row%0d mem_unsignedLoad", idx), 32'(mem_unsignedLoad), 32'(eu));
        e = (sb.size() > 0) ? sb.pop_front() : 2'b00;
        if (v.rst) e = 2'b00;
        check($sformatf("row%0d rvalid0", idx), 32'(rvalid0), 32'(e[0]));
        check($sformatf("row%0d rvalid1", idx), 32'(rvalid1), 32'(e[1]));
        check($sformatf("row%0d rdata0", idx), rdata0, e[0] ? v.mdo : 32'd0);
        check($sformatf("row%0d rdata1", idx), rdata1, e[1] ? v.mdo : 32'd0);
        sb.push_back({(v.exp_gnt == 2'd2) && (v.wm1 == 3'd0) && (v.rm1 != 3'd0),
                      (v.exp_gnt == 2'd1) && (v.wm0 == 3'd0) && (v.rm0 != 3'd0)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic rr;
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        // Reset with both ports requesting: no grant, idle memory side.
        v = both(32'h1, 32'h2, 2'd0); v.rst = 1'b1; vecs.push_back(v);
        v = both(32'h1, 32'h2, 2'd0); v.rst = 1'b1; v.lock0 = 1'b1; vecs.push_back(v);

        // Single read on port 0, data returned next cycle.
        vecs.push_back(rd(0, 32'h10, 3'd3));
        v = blank(); v.mdo = 32'hDEAD_BEEF; vecs.push_back(v);

        // Byte write on port 1 with a read mode also set: no read-valid.
        v = blank(); v.req1 = 1'b1; v.wm1 = 3'd1; v.rm1 = 3'd1; v.addr1 = 32'h3; v.wdata1 = 32'hAB;
        v.exp_gnt = 2'd2; vecs.push_back(v);
        vecs.push_back(blank());

        // Unsigned halfword read on port 1, then alternating back-to-back reads.
        v = rd(1, 32'h22, 3'd2); v.us1 = 1'b1; vecs.push_back(v);
        vecs.push_back(rd(0, 32'h100, 3'd3));
        v = rd(1, 32'h200, 3'd1); v.us1 = 1'b1; vecs.push_back(v);
        vecs.push_back(rd(0, 32'h300, 3'd5));
        vecs.push_back(blank());

        // Lock without request is ignored; WORDLEFT write with rmode set gives no read-valid.
        v = rd(1, 32'h40, 3'd3); v.lock0 = 1'b1; vecs.push_back(v);
        v = rd(0, 32'h44, 3'd3); v.wm0 = 3'd4; v.us0 = 1'b1; vecs.push_back(v);
        vecs.push_back(rd(1, 32'h48, 3'd4));

        // Contention without lock, last grant went to port 1.
        for (int i = 0; i < 4; i++)
            vecs.push_back(both(32'h500 + i, 32'h600 + i, (rr && i % 2 == 1) ? 2'd2 : 2'd1));

        // Locked burst of 20 beats with port 1 waiting: 16 beats, one yielded beat, then port 0 again.
        for (int i = 0; i < 20; i++) begin
            v = both(32'h1000 + 4 * i, 32'h2000 + 4 * i, (i == 16) ? 2'd2 : 2'd1);
            v.lock0 = 1'b1; v.wm0 = 3'd3; v.rm0 = 3'd0;
            vecs.push_back(v);
        end
        // Lock dropped while requesting: beat still granted, then back to idle arbitration.
        vecs.push_back(both(32'h3000, 32'h3004, 2'd1));
        vecs.push_back(both(32'h3008, 32'h300C, rr ? 2'd2 : 2'd1));

        // Locked read on port 1, reset in the next cycle, then idle arbitration resumes.
        v = rd(1, 32'h80, 3'd3); v.lock1 = 1'b1; vecs.push_back(v);
        v = both(32'h84, 32'h88, 2'd0); v.lock1 = 1'b1; v.rst = 1'b1; vecs.push_back(v);
        v = both(32'h8C, 32'h90, 2'd1); v.lock1 = 1'b1; vecs.push_back(v);
        vecs.push_back(blank());

        @(posedge clk);
        #1;
        foreach (vecs[i]) run_vec(vecs[i], i);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
